// File: rtl/mips_pkg.sv
// Shared MIPS constants, the fetch-entry layout and the BEQ predecode helper.
package mips_pkg;

    localparam int IMEM_AW = 6;
    localparam int INST_W  = 32;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef struct packed {
        logic [IMEM_AW-1:0] pc;
        logic [INST_W-1:0]  inst;
        logic               pred;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // A BEQ with a negative offset is taken to be a loop back-edge.
    function automatic logic is_beq_backward(input logic [INST_W-1:0] inst);
        return (inst[31:26] == OP_BEQ) && inst[15];
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus: imem address/data, decode valid/ready, execute redirect, occupancy.
interface ifetch_queue_if
    import mips_pkg::*;
#(
    parameter int AW    = IMEM_AW,
    parameter int DW    = INST_W,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          fetch_en;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          dec_valid;
    logic          dec_ready;
    logic [DW-1:0] dec_inst;
    logic [AW-1:0] dec_pc;
    logic          dec_pred_taken;
    logic          redir_valid;
    logic [AW-1:0] redir_pc;
    logic [CW-1:0] q_count;

    modport master (
        input  fetch_en, idata, dec_ready, redir_valid, redir_pc,
        output iaddr, dec_valid, dec_inst, dec_pc, dec_pred_taken, q_count
    );

    modport slave (
        output fetch_en, idata, dec_ready, redir_valid, redir_pc,
        input  iaddr, dec_valid, dec_inst, dec_pc, dec_pred_taken, q_count
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO with a registered head copy, so the head holds its last value when empty.
module ifetch_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_do_pop;
    logic             w_do_push;
    logic [PW-1:0]    w_rd_ptr_inc;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == CW'(DEPTH));
    assign w_do_pop     = i_pop & ~o_empty;
    assign w_do_push    = i_push & (~o_full | w_do_pop);
    assign w_rd_ptr_inc = r_rd_ptr + PW'(1);
    assign o_head       = r_head;
    assign o_count      = r_count;

    // Head tracks the entry that will sit at rd_ptr next cycle; a push into an empty slot bypasses storage.
    always_comb begin
        w_head_nxt = r_head;
        if (i_flush) begin
            w_head_nxt = r_head;
        end else if (w_do_pop) begin
            if (r_count > CW'(1)) begin
                w_head_nxt = r_mem[w_rd_ptr_inc];
            end else if (w_do_push) begin
                w_head_nxt = i_din;
            end else begin
                w_head_nxt = r_head;
            end
        end else if (o_empty && w_do_push) begin
            w_head_nxt = i_din;
        end else begin
            w_head_nxt = r_head;
        end
    end

    // Occupancy: flush wins, otherwise +1 / -1 / hold.
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage, pointers, occupancy and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_do_push) begin
                    r_mem[r_wr_ptr] <= i_din;
                    r_wr_ptr        <= r_wr_ptr + PW'(1);
                end
                if (w_do_pop) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
            end
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch pc, pushes imem words into a prefetch FIFO, handles redirects.
// Optional build macro IFETCH_BEQ_PREDICT_EN predicts backward BEQs as taken.
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int AW    = IMEM_AW,
    parameter int DW    = INST_W,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    ifetch_queue_if.master bus
);

    localparam int EW = AW + DW + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] w_next_pc;
    logic          w_pred;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [EW-1:0] w_din;
    logic [EW-1:0] w_head;
    logic [CW-1:0] w_count;

    assign w_pop  = ~w_empty & bus.dec_ready;
    assign w_push = bus.fetch_en & ~bus.redir_valid & (~w_full | w_pop);
    assign w_din  = {r_fetch_pc, bus.idata, w_pred};

    // Predecode of the word being pushed picks the next sequential or predicted pc.
    always_comb begin
        w_pred    = 1'b0;
        w_next_pc = r_fetch_pc + AW'(1);
`ifdef IFETCH_BEQ_PREDICT_EN
        if (is_beq_backward(bus.idata)) begin
            w_pred    = 1'b1;
            w_next_pc = r_fetch_pc + AW'(1) + bus.idata[AW-1:0];
        end else begin
            w_pred    = 1'b0;
            w_next_pc = r_fetch_pc + AW'(1);
        end
`endif
    end

    // Fetch pc: redirect beats push; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= '0;
        end else if (bus.redir_valid) begin
            r_fetch_pc <= bus.redir_pc;
        end else if (w_push) begin
            r_fetch_pc <= w_next_pc;
        end
    end

    ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redir_valid),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign bus.iaddr          = r_fetch_pc;
    assign bus.dec_valid      = ~w_empty;
    assign bus.dec_pc         = w_head[EW-1 -: AW];
    assign bus.dec_inst       = w_head[DW:1];
    assign bus.dec_pred_taken = w_head[0];
    assign bus.q_count        = w_count;

endmodule
